mul_iter16: RTL and testbench

//  Iterative shift-add integer multiplier, one operand bit per cycle. Sits in the

---
 rtl/mul_iter16.sv | 104 ++++++++++
 tb/tb_mul_iter16.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mul_iter16.sv
// Iterative shift-add multiplier: one multiplier bit per RUN cycle, then a final
// cycle that applies the sign, with valid/ready handshakes on both sides.
module mul_iter16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               accept;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s & v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;

    in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    accept   = in_valid & in_ready;

    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        // Counts 0..WIDTH-1 add partial products; count WIDTH applies the sign.
        if (cnt_q == CW'(WIDTH)) begin
          state_d = DONE;
          prod_d  = neg_q ? -acc_q : acc_q;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      mcand_d  = magnitude(a, is_signed);
      mplier_d = magnitude(b, is_signed);
      neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign prod_lo   = prod_q[WIDTH-1:0];
  assign prod_hi   = prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_iter16.sv
// Scoreboard bench for mul_iter16: the driver queues hand-computed products,
// a negedge monitor pops and compares them on each output handshake.
module tb_mul_iter16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] prod_lo;
  logic [15:0] prod_hi;
  logic        busy;

  logic [31:0] expQ[$];
  int          numChecks = 0;
  int          numPassed = 0;

  mul_iter16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .prod_lo(prod_lo), .prod_hi(prod_hi), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    numChecks++;
    if (actual === required) numPassed++;
    else $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, required);
  endtask

  // Retire-side monitor: every cycle with out_valid & out_ready consumes one result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        numChecks++;
        $display("[TB] FAIL unexpected result: actual=0x%08h required=none", {prod_hi, prod_lo});
      end else begin
        checkOutput("result", {prod_hi, prod_lo}, expQ.pop_front());
      end
    end
  end

  // Drive one request for a cycle; returns one cycle after the edge that should accept it.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input bit sgn,
                               input logic [31:0] expv, input bit record, input bit rdy);
    @(posedge clk);
    #1;
    a = av; b = bv; is_signed = sgn; in_valid = 1'b1; out_ready = rdy;
    #1;
    checkOutput("in_ready at issue", {31'b0, in_ready}, 32'd1);
    if (record) expQ.push_back(expv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, input int expLat);
    int n = 0;
    bit seen = 1'b0;
    while (n < 40 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      seen = out_valid;
    end
    if (!seen) checkOutput({name, " out_valid timeout"}, 32'd0, 32'd1);
    else checkOutput({name, " latency"}, n, expLat);
  endtask

  logic [15:0] vecA[8]   = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h8000};
  logic [15:0] vecB[8]   = '{16'hFFFF, 16'h0007, 16'h8000, 16'h8000, 16'hFFFF, 16'h0001, 16'h0001, 16'h8000};
  bit          vecS[8]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] vecExp[8] = '{32'hFFFE0001, 32'hFFFFFFEB, 32'h40000000, 32'hC0008000,
                             32'h00000000, 32'h0000FFFF, 32'hFFFFFFFF, 32'h40000000};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawValid;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset product", {prod_hi, prod_lo}, 32'd0);
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecA[i], vecB[i], vecS[i], vecExp[i], 1'b1, 1'b1);
      checkOutput("busy in RUN", {31'b0, busy}, 32'd1);
      waitResult("directed", 17);
    end

    // Backpressure: result must hold and new requests must be refused.
    applyStimulus(16'h1234, 16'h0010, 1'b0, 32'h00012340, 1'b1, 1'b0);
    waitResult("backpressure", 17);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      a = 16'hAAAA; b = 16'h5555; in_valid = i[0];
      #1;
      checkOutput("held product", {prod_hi, prod_lo}, 32'h00012340);
      checkOutput("held out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("in_ready in DONE", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    applyStimulus(16'd2, 16'd3, 1'b0, 32'd6, 1'b1, 1'b1);
    checkOutput("back-to-back busy", {31'b0, busy}, 32'd1);
    waitResult("back-to-back", 17);

    // Abort with reset part-way through RUN.
    applyStimulus(16'h0F0F, 16'h0003, 1'b0, 32'h0, 1'b0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abort out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    checkOutput("abort in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("abort product", {prod_hi, prod_lo}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      sawValid = sawValid | out_valid;
    end
    checkOutput("no result after abort", {31'b0, sawValid}, 32'd0);

    applyStimulus(16'd5, 16'd4, 1'b0, 32'd20, 1'b1, 1'b1);
    waitResult("after abort", 17);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
